seg_bcd_ctrl: RTL

Sequencing controller that feeds the four-digit seven-segment multiplexer. It accepts a binary value from the PWM datapath (for example a duty-cycle count) through a valid/ready handshake. A multi-cycle shift-add-3 (double-dabble) engine converts the value to four BCD digits, and the controller then updates the digit registers atomically. Its dig0..dig3 outputs drive the multiplexer's in0..in3 inputs directly.

---
 rtl/seg_pkg.sv | 35 +++
 rtl/seg_bcd_ctrl_bcd_add3.sv | 12 +
 rtl/seg_bcd_ctrl.sv | 121 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: controller state
// encoding, digit width and the special digit codes understood by the decoder.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int BCD_W   = 4 * DIGIT_W;

    localparam int                 MAX_VALUE  = 9999;
    localparam logic [DIGIT_W-1:0] DASH_CODE  = 4'd10;
    localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'd15;

    // Replace leading zero digits (from the top nibble downward) with the
    // blank code; the lowest digit always stays visible so 0 still shows.
    function automatic logic [BCD_W-1:0] blank_leading(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        logic             lead;
        r    = bcd;
        lead = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            if (lead && (bcd[i*DIGIT_W +: DIGIT_W] == '0)) begin
                r[i*DIGIT_W +: DIGIT_W] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_bcd_ctrl_bcd_add3.sv
// Double-dabble nibble correction: a BCD digit of 5 or more gets 3 added
// before the shift so that it carries correctly into the next digit.
module bcd_add3
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/seg_bcd_ctrl.sv
// Binary-to-BCD sequencing controller for the four-digit display multiplexer.
// A value is accepted over a valid/ready handshake, converted by a W-cycle
// shift-add-3 engine and then loaded into the digit registers in one step.
// Optional build macro: LEADING_BLANK_EN (blank leading zero digits).
//
// Handshake: a value transfers on a rising edge where value_valid and
// value_ready are both high; value_ready is registered and is only high in
// IDLE, so value_in is ignored at every other time.
module seg_bcd_ctrl
    import seg_pkg::*;
#(
    parameter int W = 14
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [W-1:0]       value_in,
    input  logic               value_valid,
    output logic               value_ready,
    output logic [DIGIT_W-1:0] dig0,
    output logic [DIGIT_W-1:0] dig1,
    output logic [DIGIT_W-1:0] dig2,
    output logic [DIGIT_W-1:0] dig3,
    output logic               update,
    output logic               overflow,
    output state_t             dbg_state
);

    localparam int              CNT_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    state_t           state;
    logic [W-1:0]     bin_q;
    logic [BCD_W-1:0] bcd_q;
    logic [CNT_W-1:0] cnt_q;
    logic [BCD_W-1:0] bcd_adj;
    logic [BCD_W-1:0] load_word;
    logic             value_over;

    assign dbg_state  = state;
    assign value_over = 32'(value_in) > MAX_VALUE;

    // Per-nibble add-3 correction applied ahead of every shift.
    for (genvar g = 0; g < 4; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd_q[g*DIGIT_W +: DIGIT_W]),
            .dout (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Digit pattern presented to the output registers when leaving LOAD.
    always_comb begin
        load_word = bcd_q;
        if (overflow) begin
            load_word = {4{DASH_CODE}};
        end else begin
`ifdef LEADING_BLANK_EN
            load_word = blank_leading(bcd_q);
`else
            load_word = bcd_q;
`endif
        end
    end

    // Controller FSM: accept, shift W times, then load the digits atomically.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            value_ready <= 1'b1;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            dig0        <= '0;
            dig1        <= '0;
            dig2        <= '0;
            dig3        <= '0;
            update      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (value_valid && value_ready) begin
                        value_ready <= 1'b0;
                        if (value_over) begin
                            overflow <= 1'b1;
                            state    <= LOAD;
                        end else begin
                            bin_q    <= value_in;
                            bcd_q    <= '0;
                            cnt_q    <= '0;
                            overflow <= 1'b0;
                            state    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[W-1]};
                    bin_q <= {bin_q[W-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    dig0        <= load_word[0*DIGIT_W +: DIGIT_W];
                    dig1        <= load_word[1*DIGIT_W +: DIGIT_W];
                    dig2        <= load_word[2*DIGIT_W +: DIGIT_W];
                    dig3        <= load_word[3*DIGIT_W +: DIGIT_W];
                    update      <= 1'b1;
                    value_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    value_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
